// File: rtl/collatz_pkg.sv
// Shared types and constants for the Collatz range engine.
package collatz_pkg;

  // Default width of a stored sequence length.
  localparam int COUNT_BITS_DEF = 16;

  // Saturated length marker (all ones) at the default width.
  localparam logic [COUNT_BITS_DEF-1:0] LEN_SAT = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_STORE,
    S_DONE
  } state_t;

endpackage

// File: rtl/collatz_step_unit.sv
// One Collatz step: halve even values, 3n+1 odd values, flag 32-bit overflow.
module collatz_step_unit (
  input  logic [31:0] n,
  output logic [31:0] n_next,
  output logic        is_one,
  output logic        overflow
);

  logic [33:0] tri_n;

  // 3n+1 evaluated at 34 bits so the carry-out is visible.
  always_comb begin
    tri_n    = ({2'b00, n} << 1) + {2'b00, n} + 34'd1;
    is_one   = (n == 32'd1);
    overflow = n[0] & (|tri_n[33:32]);
    n_next   = n[0] ? tri_n[31:0] : {1'b0, n[31:1]};
  end

endmodule

// File: rtl/collatz_range_engine.sv
// Computes Collatz lengths for base..base+RAM_WORDS-1 into a RAM, then serves reads.
module collatz_range_engine
  import collatz_pkg::*;
#(
  parameter int RAM_WORDS     = 256,
  parameter int RAM_ADDR_BITS = 8,   // 2**RAM_ADDR_BITS must equal RAM_WORDS
  parameter int COUNT_BITS    = COUNT_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  go,
  input  logic [31:0]           start,
  output logic                  done,
  output logic [COUNT_BITS-1:0] count
);

  localparam logic [COUNT_BITS-1:0] SAT =
    (COUNT_BITS == COUNT_BITS_DEF) ? COUNT_BITS'(LEN_SAT) : {COUNT_BITS{1'b1}};
  localparam logic [RAM_ADDR_BITS-1:0] LAST_IDX = RAM_ADDR_BITS'(RAM_WORDS - 1);

  state_t                   state;
  logic                     go_q;
  logic                     go_rise;
  logic [31:0]              base;
  logic [RAM_ADDR_BITS-1:0] index;
  logic [31:0]              n;
  logic [COUNT_BITS-1:0]    len;
  logic [31:0]              value;
  logic [31:0]              n_next;
  logic                     is_one;
  logic                     overflow;
  logic [COUNT_BITS-1:0]    rd_data;
  logic [COUNT_BITS-1:0]    ram [RAM_WORDS];

  // A held go level only counts once, on its first sampled cycle.
  assign go_rise = go & ~go_q;
  assign value   = base + {{(32 - RAM_ADDR_BITS){1'b0}}, index};

  collatz_step_unit u_step (
    .n        (n),
    .n_next   (n_next),
    .is_one   (is_one),
    .overflow (overflow)
  );

  // Control FSM: go from any state restarts the whole range; done is registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      go_q  <= 1'b0;
      done  <= 1'b0;
      index <= '0;
      base  <= '0;
      n     <= '0;
      len   <= '0;
    end else begin
      go_q <= go;
      if (go_rise) begin
        base  <= start;
        index <= '0;
        done  <= 1'b0;
        state <= S_LOAD;
      end else begin
        case (state)
          S_IDLE: ;
          S_LOAD: begin
            n     <= value;
            len   <= (value == 32'd0) ? '0 : COUNT_BITS'(1);
            state <= S_RUN;
          end
          S_RUN: begin
            if (is_one || len == '0) begin
              state <= S_STORE;
            end else if (len == SAT) begin
              state <= S_STORE;
            end else if (overflow) begin
              len   <= SAT;
              state <= S_STORE;
            end else begin
              n   <= n_next;
              len <= len + COUNT_BITS'(1);
            end
          end
          S_STORE: begin
            if (index == LAST_IDX) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              index <= index + RAM_ADDR_BITS'(1);
              state <= S_LOAD;
            end
          end
          S_DONE: ;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Result RAM: write in STORE, synchronous read in DONE; no reset so it maps to block RAM.
  always_ff @(posedge clk) begin
    if (state == S_STORE) ram[index] <= len;
    if (state == S_DONE)  rd_data <= ram[start[RAM_ADDR_BITS-1:0]];
  end

  // Read data is only exposed once the whole range is valid.
  assign count = done ? rd_data : '0;

endmodule

// File: tb/tb_collatz_range_engine.sv
// Self-checking bench: behavioural Collatz model, per-cycle output monitor, directed and random runs.
module tb_collatz_range_engine;

  localparam int W  = 64;
  localparam int AB = 6;
  localparam int SATV = 65535;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        go = 1'b0;
  logic [31:0] start = '0;
  logic        done;
  logic [15:0] count;

  int n_cmp = 0;
  int n_err = 0;

  int unsigned pend_mem [W];
  int unsigned exp_mem  [W];
  logic [AB-1:0] last_addr = '0;
  logic          last_done = 1'b0;

  collatz_range_engine #(.RAM_WORDS(W), .RAM_ADDR_BITS(AB), .COUNT_BITS(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .go    (go),
    .start (start),
    .done  (done),
    .count (count)
  );

  always #5 clk = ~clk;

  // Collatz length straight from the definition, with 32-bit overflow and 16-bit saturation.
  function automatic int unsigned coll_len(input longint unsigned v);
    longint unsigned x;
    int unsigned l;
    if (v == 0) return 0;
    x = v;
    l = 1;
    forever begin
      if (x == 1) return l;
      if (l == SATV) return l;
      if ((x % 2 == 1) && (3 * x + 1 > 64'hFFFF_FFFF)) return SATV;
      x = (x % 2 == 1) ? 3 * x + 1 : x / 2;
      l = l + 1;
    end
  endfunction

  task automatic check(input string nm, input longint unsigned act, input longint unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Every cycle: count must be 0 while done is low, and the model word of last cycle's address once done has settled.
  always @(negedge clk) begin
    if (!done) check("gate", count, 0);
    else if (last_done) check("mon", count, exp_mem[last_addr]);
    if (done && !last_done) exp_mem = pend_mem;
    last_addr = start[AB-1:0];
    last_done = done;
  end

  task automatic cyc(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_go(input logic [31:0] b, input int hold);
    logic [31:0] v;
    @(posedge clk); #1;
    go = 1'b1;
    start = b;
    for (int i = 0; i < W; i++) begin
      v = b + 32'(i);
      pend_mem[i] = coll_len(longint'(v));
    end
    cyc(hold);
    go = 1'b0;
    check("done_low_after_go", done, 0);
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (!done && k < budget) begin
      cyc(1);
      k++;
    end
    check("done_timeout", done, 1);
  endtask

  task automatic rd(input int a, input int unsigned exp, input string nm);
    @(posedge clk); #1;
    start = 32'(a);
    cyc(1);
    check(nm, count, exp);
  endtask

  initial begin
    // Pin the model on hand-computed values.
    check("pin_len1", coll_len(1), 1);
    check("pin_len2", coll_len(2), 2);
    check("pin_len3", coll_len(3), 8);
    check("pin_len27", coll_len(27), 112);
    check("pin_len0", coll_len(0), 0);
    check("pin_len100", coll_len(100), 26);
    check("pin_ovf", coll_len(64'hFFFF_FFFF), SATV);

    // Reset state
    rst_n = 1'b0;
    cyc(3);
    check("rst_done", done, 0);
    check("rst_count", count, 0);
    rst_n = 1'b1;
    cyc(2);

    // Basic run from 1, with a pre-done read gated to 0
    run_go(32'd1, 1);
    start = 32'd2;
    cyc(3);
    check("predone_count", count, 0);
    wait_done(40000);
    cyc(2);
    rd(0, 1, "b1_a0");
    rd(1, 2, "b1_a1");
    rd(2, 8, "b1_a2");
    rd(26, 112, "b1_a26");

    // Latency: address 2 then 3; 3 (N=4) only shows one cycle later
    rd(2, 8, "lat_a2");
    @(posedge clk); #1;
    start = 32'd3;
    @(negedge clk);
    check("lat_old", count, 8);
    @(posedge clk); #1;
    check("lat_new", count, 3);

    // Zero base
    run_go(32'd0, 1);
    wait_done(40000);
    cyc(2);
    rd(0, 0, "b0_a0");
    rd(1, 1, "b0_a1");
    rd(3, 8, "b0_a3");

    // Restart mid-run: done never rises for the aborted run
    run_go(32'd1, 1);
    for (int i = 0; i < 500; i++) begin
      cyc(1);
      check("restart_done_low", done, 0);
    end
    run_go(32'd100, 1);
    wait_done(40000);
    cyc(2);
    rd(0, 26, "rs_a0");
    rd(1, 26, "rs_a1");

    // Reset mid-run
    run_go(32'd1, 1);
    cyc(50);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    for (int i = 0; i < 300; i++) begin
      cyc(1);
      check("rstmid_done", done, 0);
      check("rstmid_count", count, 0);
    end
    run_go(32'd7, 3);  // held go level is one request
    wait_done(40000);
    cyc(2);
    rd(0, 17, "b7_a0");

    // Overflow saturation and 32-bit wrap
    run_go(32'hFFFF_FFFF, 1);
    wait_done(40000);
    cyc(2);
    rd(0, 16'hFFFF, "ovf_a0");
    rd(1, 0, "ovf_a1");
    rd(2, 1, "ovf_a2");

    // Random bases with random reads against the model
    for (int r = 0; r < 3; r++) begin
      int a;
      run_go(32'($urandom_range(0, 65535)), 1);
      wait_done(40000);
      cyc(2);
      for (int j = 0; j < 30; j++) begin
        a = int'($urandom_range(0, W - 1));
        rd(a, pend_mem[a], "rand_rd");
      end
    end

    cyc(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
